// File: rtl/led_display.sv
// ---------------------------------------------------------------------------
// led_display: 8-digit multiplexed seven-segment display fed by an ASCII
// character stream. Accepted characters shift into an 8-entry buffer from
// the right (digit 0). The digits are scanned one at a time, and each digit
// stays enabled for SCAN_CYCLES clocks. EN and SEGS are active-low outputs.
//
// Optional feature: define LED_DISPLAY_HEX_EN to also accept the ASCII
// letters 'A'..'F' and 'a'..'f' as the hex values 10..15.
// ---------------------------------------------------------------------------
module led_display #(
    parameter int SCAN_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] recv_data,
    input  logic       recv_valid,
    output logic [7:0] EN,
    output logic [7:0] SEGS
);

    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_CYCLES - 1);

    // One buffer entry: a 4-bit hex value plus a blank flag.
    typedef struct packed {
        logic       blank;
        logic [3:0] val;
    } entry_t;

    localparam entry_t BLANK_ENTRY = '{blank: 1'b1, val: 4'h0};

    entry_t [7:0]     buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       en_q, en_d;
    logic [7:0]       segs_q, segs_d;

    logic             accept;
    logic [3:0]       char_val;

    // Active-low segment pattern {a,b,c,d,e,f,g,dp}; dp is always off.
    function automatic logic [7:0] seg_code(input entry_t e);
        logic [7:0] code;
        if (e.blank) begin
            code = 8'hFF;
        end else begin
            case (e.val)
                4'h0:    code = 8'h03;
                4'h1:    code = 8'h9F;
                4'h2:    code = 8'h25;
                4'h3:    code = 8'h0D;
                4'h4:    code = 8'h99;
                4'h5:    code = 8'h49;
                4'h6:    code = 8'h41;
                4'h7:    code = 8'h1F;
                4'h8:    code = 8'h01;
                4'h9:    code = 8'h09;
                4'hA:    code = 8'h11;
                4'hB:    code = 8'hC1;
                4'hC:    code = 8'h63;
                4'hD:    code = 8'h85;
                4'hE:    code = 8'h61;
                default: code = 8'h71;
            endcase
        end
        return code;
    endfunction

    // Classify the incoming ASCII code and extract its hex value.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals; no latch is inferred.
        accept   = 1'b0;
        char_val = 4'h0;
        if (recv_data >= 8'h30 && recv_data <= 8'h39) begin
            accept   = 1'b1;
            char_val = recv_data[3:0];
        end
`ifdef LED_DISPLAY_HEX_EN
        else if ((recv_data >= 8'h41 && recv_data <= 8'h46) ||
                 (recv_data >= 8'h61 && recv_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 maps them to 10.
            accept   = 1'b1;
            char_val = recv_data[3:0] + 4'd9;
        end
`endif
    end

    // Next-state logic: buffer shift, scan timing and the output registers.
    always_comb begin
        buf_d = buf_q;
        if (recv_valid && accept) begin
            buf_d = {buf_q[6:0], entry_t'{blank: 1'b0, val: char_val}};
        end

        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        en_d   = ~(8'b1 << idx_q);
        segs_d = seg_code(buf_q[idx_q]);
    end

    // State registers; reset blanks the display and restarts the scan at digit 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the buffer is only 8 small entries, so it is reset like any other
        // flop; that is what guarantees a blank display straight out of reset.
        if (rst) begin
            buf_q  <= {8{BLANK_ENTRY}};
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            en_q   <= 8'hFF;
            segs_q <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            en_q   <= en_d;
            segs_q <= segs_d;
        end
    end

    assign EN   = en_q;
    assign SEGS = segs_q;

endmodule

// File: tb/tb_led_display.sv
// ---------------------------------------------------------------------------
// tb_led_display: scoreboard bench for led_display with SCAN_CYCLES = 4.
// Stimulus pushes the expected {EN, SEGS} pairs of a whole frame into a
// queue; the monitor pops an entry whenever the DUT presents that EN value
// and compares SEGS. Expected segment codes are given by hand per character.
// Build with +define+LED_DISPLAY_HEX_EN to exercise the hex letters.
// ---------------------------------------------------------------------------
module tb_led_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic [7:0] EN;
    logic [7:0] SEGS;

    led_display #(.SCAN_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .EN         (EN),
        .SEGS       (SEGS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] en;
        logic [7:0] segs;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model [8];   // expected SEGS code per digit
    int         n_total = 0;
    int         n_pass  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: compare SEGS whenever the DUT shows the digit at the queue head,
    // and check that the digit enable walks FE,FD,...,7F,FE.
    logic [7:0] en_prev = 8'hFF;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && EN === exp_q[0].en) begin
            e = exp_q.pop_front();
            check(e.name, SEGS, e.segs);
        end
        if (rst) begin
            en_prev = 8'hFF;
        end else begin
            if (en_prev != 8'hFF && EN != en_prev)
                check("en_rotate", EN, {en_prev[6:0], en_prev[7]});
            en_prev = EN;
        end
    end

    task automatic push(input logic [7:0] en, input logic [7:0] segs, input string name);
        exp_t e;
        e.en = en; e.segs = segs; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input string name);
        for (int d = 0; d < 8; d++)
            push(~(8'b1 << d), model[d], $sformatf("%s_d%0d", name, d));
    endtask

    // Wait (bounded) for the monitor to consume every queued expectation.
    task automatic drain();
        exp_t e;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            $display("FAIL timeout_%s: EN %h never shown, last EN %h", e.name, e.en, EN);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 8; d++) model[d] = 8'hFF;
    endtask

    task automatic model_shift(input logic [7:0] code);
        for (int d = 7; d > 0; d--) model[d] = model[d-1];
        model[0] = code;
    endtask

    // Drive one character with recv_valid high for 'cycles' sampled edges.
    task automatic send(input logic [7:0] ch, input int cycles);
        @(negedge clk);
        recv_data  = ch;
        recv_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        recv_valid = 1'b0;
    endtask

    task automatic settle_and_check(input string name);
        repeat (2) @(negedge clk);
        push_frame(name);
        drain();
    endtask

    logic [7:0] digits   [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] dig_segs [9] = '{8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    logic [7:0] junk     [7] = '{8'h2A, 8'h47, 8'h2F, 8'h3A, 8'h40, 8'h60, 8'h67};

    initial begin
        rst        = 1'b1;
        recv_data  = 8'h00;
        recv_valid = 1'b0;
        model_clear();

        // Reset held: display dark.
        push(8'hFF, 8'hFF, "reset_hold");
        repeat (3) @(negedge clk);
        drain();

        // Release: first edge enables digit 0, all digits blank.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_en_after_reset", EN, 8'hFE);
        check("first_segs_after_reset", SEGS, 8'hFF);
        settle_and_check("blank");

        // Single '1'.
        send(8'h31, 1);
        model_shift(8'h9F);
        settle_and_check("one");

        // '1'..'9': digits 7..0 show 2..9.
        for (int i = 0; i < 9; i++) begin
            send(digits[i], 1);
            model_shift(dig_segs[i]);
        end
        settle_and_check("seq");

        // Non-accepted codes and data without recv_valid leave the buffer alone.
        for (int i = 0; i < 7; i++) send(junk[i], 1);
        @(negedge clk);
        recv_data = 8'h35;
        repeat (3) @(negedge clk);
        settle_and_check("ignored");

        // Hex letters: shown in the hex build, ignored otherwise.
        send(8'h61, 1);
`ifdef LED_DISPLAY_HEX_EN
        model_shift(8'h11);
`endif
        settle_and_check("hex_a");
        send(8'h46, 1);
`ifdef LED_DISPLAY_HEX_EN
        model_shift(8'h71);
`endif
        settle_and_check("hex_F");

        // recv_valid held 3 cycles: three shifts of '5'.
        send(8'h35, 3);
        for (int i = 0; i < 3; i++) model_shift(8'h49);
        settle_and_check("hold3");

        // Reset mid-frame while a character is pending.
        @(negedge clk);
        recv_data  = 8'h37;
        recv_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_en", EN, 8'hFF);
        check("async_reset_segs", SEGS, 8'hFF);
        push(8'hFF, 8'hFF, "reset_mid");
        repeat (3) @(negedge clk);
        drain();
        recv_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        settle_and_check("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/led_display.md
LED_DISPLAY -- requirements
Module: led_display

Interface
REQ-001 The parameter SCAN_CYCLES SHALL default to 20000 and set the number of clock cycles each digit stays enabled (0.2 ms at 100 MHz).
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the single system clock, with all state updating on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
REQ-004 The port recv_data SHALL be an input, 8 bits wide, carrying the received ASCII character.
REQ-005 The port recv_valid SHALL be an input, 1 bit wide, and mark recv_data as valid for one sampled cycle.
REQ-006 The port EN SHALL be an output, 8 bits wide, of active-low digit enables, with EN[0] driving the rightmost digit and EN[7] the leftmost.
REQ-007 The port SEGS SHALL be an output, 8 bits wide, of active-low segment drives in the order {a,b,c,d,e,f,g,dp} from bit 7 down to bit 0.

Function
REQ-008 The block SHALL hold an 8-entry character buffer; each entry holds a 4-bit hex value plus a blank flag.
REQ-009 On each rising clk edge where recv_valid=1 and recv_data is an accepted character, the buffer SHALL shift one place left, discarding entry 7, and load the new value into entry 0.
REQ-010 ASCII '0'..'9' (0x30..0x39) SHALL be accepted as values 0..9.
REQ-011 Characters that are not accepted SHALL leave the buffer unchanged, and recv_data SHALL be ignored whenever recv_valid=0.
REQ-012 A 1-cycle recv_valid pulse SHALL cause exactly one shift, and recv_valid held high for N cycles SHALL cause N shifts.
REQ-013 A scan counter SHALL count 0..SCAN_CYCLES-1; on wrap, the digit index SHALL advance 0->1->...->7->0.
REQ-014 EN and SEGS SHALL be registered and updated every cycle from the current digit index and buffer entry, so a buffer update is visible no later than one cycle after the scan reaches that digit.
REQ-015 EN SHALL have exactly one bit low, namely bit index, during scanning.
REQ-016 SEGS SHALL use these active-low codes: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71, blank=FF.
REQ-017 The decimal point (SEGS[0]) SHALL always be off, i.e. driven 1.
REQ-018 If a shift coincides with the scan reaching a digit, that digit SHALL display the post-shift content from the following cycle.

Reset
REQ-019 While rst=1, EN SHALL be 8'hFF and SEGS SHALL be 8'hFF.
REQ-020 While rst=1, all buffer entries SHALL be blank, and the scan counter and digit index SHALL be 0.
REQ-021 A reset asserted mid-scan or during recv_valid SHALL take effect immediately and discard the pending character.
REQ-022 The first enabled digit after rst deasserts SHALL be digit 0, with EN=8'hFE on the first clock edge after reset release.

Configuration
REQ-023 With the macro LED_DISPLAY_HEX_EN defined, ASCII 'A'..'F' (0x41..0x46) and 'a'..'f' (0x61..0x66) SHALL additionally be accepted as values 10..15.
REQ-024 With LED_DISPLAY_HEX_EN undefined, only '0'..'9' SHALL be accepted, and all other codes SHALL be ignored.

Verification (SCAN_CYCLES=4 in simulation)
REQ-025 Hold rst=1 -> EN=FF and SEGS=FF, and after release the digit enables cycle FE,FD,FB,...,7F with every digit blank (SEGS=FF).
REQ-026 Pulse recv_valid with 0x31 ('1') -> when EN=FE, SEGS=9F; all other digits stay FF.
REQ-027 Send 0x31..0x39 in sequence -> digits 7..0 show 2..9 (EN=7F gives 25, EN=FE gives 09), and '1' is discarded.
REQ-028 Send 0x2A ('*') and 0x47 ('G') -> buffer unchanged; with LED_DISPLAY_HEX_EN defined, 0x61 shows 11 and 0x46 shows 71 on digit 0, and without the macro both are ignored.
REQ-029 Assert rst mid-frame with recv_valid=1 -> EN=FF and SEGS=FF at once, and all digits are blank after release.
REQ-030 Hold recv_valid=1 for 3 cycles with 0x35 -> digits 2..0 show 49, with the previously held digits shifted left by 3.
